// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, branch-flush and multi-cycle matrix hold sequencing with stall/flush counters
module hazard_ctrl #(
  parameter int MTX_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_mtx_start,
  input  logic             ex_br_taken,
  output logic             ctrl_stall,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             ex_hold,
  output logic             mtx_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic       lu, mh;
  always_comb begin
    lu = ex_mem_read && ex_rd != 5'd0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    mh = (state == IDLE) ? ex_mtx_start : (cnt > 4'd1);
    state_nx = (state == IDLE) ? (ex_mtx_start ? BUSY : IDLE) : (cnt == 4'd1 ? IDLE : BUSY);
    cnt_nx = (state == IDLE) ? (ex_mtx_start ? 4'(MTX_LAT - 1) : cnt) : cnt - 4'd1;
    ex_hold = mh;
    pc_hold = mh || (!ex_br_taken && lu);
    if_id_hold = pc_hold;
    if_id_flush = !mh && ex_br_taken;
    ctrl_stall = !mh && (ex_br_taken || lu);
    mtx_busy = state == BUSY;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      stall_cnt <= stall_cnt + CNT_W'(pc_hold);
      flush_cnt <= flush_cnt + CNT_W'(if_id_flush);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with MTX_LAT=4
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_mtx_start, ex_br_taken;
  logic        ctrl_stall, pc_hold, if_id_hold, if_id_flush, ex_hold, mtx_busy;
  logic [31:0] stall_cnt, flush_cnt;
  logic [5:0]  outs;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_stall, exp_flush;
  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, ms, br;
    logic [5:0] e;
  } vec_t;
  typedef struct packed {
    logic [5:0]  e;
    logic [31:0] st, fl;
  } sb_t;
  sb_t sb[$];
  sb_t s;
  localparam logic [5:0] NONE = 6'b000000, LU = 6'b111000, MH_I = 6'b011010,
                         MH_B = 6'b011011, REL = 6'b000001, BR = 6'b100100, REL_BR = 6'b100101;
  hazard_ctrl #(.MTX_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_mtx_start(ex_mtx_start), .ex_br_taken(ex_br_taken), .ctrl_stall(ctrl_stall),
    .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
    .ex_hold(ex_hold), .mtx_busy(mtx_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  assign outs = {ctrl_stall, pc_hold, if_id_hold, if_id_flush, ex_hold, mtx_busy};
  task automatic drive(input vec_t v);
    @(posedge clk);
    #1;
    id_rs1 = v.rs1;
    id_rs2 = v.rs2;
    ex_rd = v.rd;
    id_use_rs1 = v.u1;
    id_use_rs2 = v.u2;
    ex_mem_read = v.mr;
    ex_mtx_start = v.ms;
    ex_br_taken = v.br;
    sb.push_back('{v.e, exp_stall, exp_flush});
    exp_stall += 32'(v.e[4]);
    exp_flush += 32'(v.e[2]);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    {id_rs1, id_rs2, ex_rd, id_use_rs1, id_use_rs2, ex_mem_read, ex_mtx_start, ex_br_taken} = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_stall = '0;
    exp_flush = '0;
    sb.delete();
  endtask
  task automatic test_reset();
    {id_rs1, id_rs2, ex_rd, id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken} = '0;
    ex_mtx_start = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mtx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", mtx_busy); end
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
    checks++;
    if (outs !== MH_I) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs, MH_I); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (ex_hold !== 1'b1 || mtx_busy !== 1'b0) begin
      failures++; $display("FAIL reset_release got=%b%b exp=10", ex_hold, mtx_busy);
    end
  endtask
  task automatic test_load_use();
    vec_t v[6];
    v = '{'{5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, LU},
          '{5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NONE},
          '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NONE},
          '{5'd0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NONE},
          '{5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, LU},
          '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE}};
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      @(negedge clk);
      s = sb.pop_front();
      checks++;
      if (outs !== s.e) begin failures++; $display("FAIL load_use[%0d] outs got=%b exp=%b", i, outs, s.e); end
      checks++;
      if (stall_cnt !== s.st) begin failures++; $display("FAIL load_use[%0d] stall_cnt got=%0d exp=%0d", i, stall_cnt, s.st); end
      checks++;
      if (flush_cnt !== s.fl) begin failures++; $display("FAIL load_use[%0d] flush_cnt got=%0d exp=%0d", i, flush_cnt, s.fl); end
    end
  endtask
  task automatic test_matrix();
    vec_t v[6];
    v = '{'{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, MH_I},
          '{5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, MH_B},
          '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, MH_B},
          '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, REL_BR},
          '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE},
          '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE}};
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      @(negedge clk);
      s = sb.pop_front();
      checks++;
      if (outs !== s.e) begin failures++; $display("FAIL matrix[%0d] outs got=%b exp=%b", i, outs, s.e); end
      checks++;
      if (stall_cnt !== s.st) begin failures++; $display("FAIL matrix[%0d] stall_cnt got=%0d exp=%0d", i, stall_cnt, s.st); end
      checks++;
      if (flush_cnt !== s.fl) begin failures++; $display("FAIL matrix[%0d] flush_cnt got=%0d exp=%0d", i, flush_cnt, s.fl); end
    end
  endtask
  task automatic test_back_to_back();
    logic [5:0] e[10];
    vec_t v;
    e = '{MH_I, MH_B, MH_B, REL, MH_I, MH_B, MH_B, REL, NONE, NONE};
    for (int i = 0; i < 10; i++) begin
      v = '0;
      v.ms = i < 8;
      v.e = e[i];
      drive(v);
      @(negedge clk);
      s = sb.pop_front();
      checks++;
      if (outs !== s.e) begin failures++; $display("FAIL b2b[%0d] outs got=%b exp=%b", i, outs, s.e); end
      checks++;
      if (stall_cnt !== s.st) begin failures++; $display("FAIL b2b[%0d] stall_cnt got=%0d exp=%0d", i, stall_cnt, s.st); end
      checks++;
      if (flush_cnt !== s.fl) begin failures++; $display("FAIL b2b[%0d] flush_cnt got=%0d exp=%0d", i, flush_cnt, s.fl); end
    end
  endtask
  task automatic test_branch_priority();
    vec_t v[7];
    v = '{'{5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, BR},
          '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE},
          '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, MH_I},
          '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, MH_B},
          '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, MH_B},
          '{5'd0, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'b111001},
          '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NONE}};
    for (int i = 0; i < 7; i++) begin
      drive(v[i]);
      @(negedge clk);
      s = sb.pop_front();
      checks++;
      if (outs !== s.e) begin failures++; $display("FAIL branch[%0d] outs got=%b exp=%b", i, outs, s.e); end
      checks++;
      if (stall_cnt !== s.st) begin failures++; $display("FAIL branch[%0d] stall_cnt got=%0d exp=%0d", i, stall_cnt, s.st); end
      checks++;
      if (flush_cnt !== s.fl) begin failures++; $display("FAIL branch[%0d] flush_cnt got=%0d exp=%0d", i, flush_cnt, s.fl); end
    end
  endtask
  task automatic test_reset_mid_busy();
    logic [5:0] e[8];
    vec_t v;
    e = '{MH_I, MH_B, MH_B, MH_I, MH_B, MH_B, REL, NONE};
    for (int i = 0; i < 8; i++) begin
      v = '0;
      v.ms = (i < 2) || (i > 2 && i < 7);
      v.e = e[i];
      drive(v);
      @(negedge clk);
      s = sb.pop_front();
      checks++;
      if (outs !== s.e) begin failures++; $display("FAIL mid_busy[%0d] outs got=%b exp=%b", i, outs, s.e); end
      checks++;
      if (stall_cnt !== s.st) begin failures++; $display("FAIL mid_busy[%0d] stall_cnt got=%0d exp=%0d", i, stall_cnt, s.st); end
      if (i == 2) begin
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (ex_hold !== 1'b0 || mtx_busy !== 1'b0 || stall_cnt !== 32'd0) begin
          failures++; $display("FAIL mid_busy_abort hold=%b busy=%b stall=%0d exp=0/0/0", ex_hold, mtx_busy, stall_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_stall = '0;
        exp_flush = '0;
      end
    end
  endtask
  initial begin
    exp_stall = '0;
    exp_flush = '0;
    test_reset();
    do_reset();
    test_load_use();
    do_reset();
    test_matrix();
    do_reset();
    test_back_to_back();
    do_reset();
    test_branch_priority();
    do_reset();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
